// File: rtl/spi_dac_mc.sv
// Multi-channel serial DAC write engine: NCH independent dout/sclk/sync_n lanes, one-word buffer each.
// Optional macro SPI_DAC_DEDUP_EN drops a buffered word identical to the last word sent on that channel.
module spi_dac_mc #(
    parameter int NCH     = 2,
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 1,
    parameter int GAP_CYC = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH*DATA_W-1:0] in_data,
    input  logic [NCH-1:0]        in_valid,
    output logic [NCH-1:0]        in_ready,
    output logic [NCH-1:0]        dout,
    output logic [NCH-1:0]        sclk,
    output logic [NCH-1:0]        sync_n,
    output logic [NCH-1:0]        busy,
    output logic [NCH-1:0]        done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_W);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [1:0]        state;
        logic              buf_empty;
        logic              buf_full;
        logic [DATA_W-1:0] buf_data;
        logic [DATA_W-1:0] shreg;
        logic [DIV_W-1:0]  div_cnt;
        logic [BIT_W-1:0]  bit_cnt;
        logic [GAP_W-1:0]  gap_cnt;
        logic              dout_r;
        logic              sclk_r;
        logic              sync_r;
        logic              done_r;
        logic              drop;
        logic              load_slot;
        logic              load_go;
        logic              shift_step;

        assign buf_full   = ~buf_empty;
        assign load_slot  = (state == IDLE) || ((state == GAP) && (gap_cnt == GAP_LAST));
        assign load_go    = buf_full && load_slot && !drop;
        assign shift_step = (state == SHIFT) && (div_cnt == DIV_LAST) && !sclk_r
                            && (bit_cnt != BIT_LAST);

`ifdef SPI_DAC_DEDUP_EN
        logic [DATA_W-1:0] last_sent;
        logic              last_vld;

        assign drop = last_vld && (buf_data == last_sent);

        always_ff @(posedge clk) begin
            if (reset) begin
                last_vld <= 1'b0;
            end else if (load_go) begin
                last_vld  <= 1'b1;
                last_sent <= buf_data;
            end
        end
`else
        assign drop = 1'b0;
`endif

        // Data path: buffer capture and shift register, no reset needed.
        always_ff @(posedge clk) begin
            if (in_valid[k] && buf_empty) begin
                buf_data <= in_data[k*DATA_W +: DATA_W];
            end
            if (load_go) begin
                shreg <= buf_data;
            end else if (shift_step) begin
                shreg <= {shreg[DATA_W-2:0], 1'b0};
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state     <= IDLE;
                buf_empty <= 1'b1;
                dout_r    <= 1'b0;
                sclk_r    <= 1'b1;
                sync_r    <= 1'b1;
                done_r    <= 1'b0;
                div_cnt   <= '0;
                bit_cnt   <= '0;
                gap_cnt   <= '0;
            end else begin
                done_r <= 1'b0;
                // A dropped word empties the buffer exactly like a loaded one.
                if (in_valid[k] && buf_empty) begin
                    buf_empty <= 1'b0;
                end else if (buf_full && load_slot) begin
                    buf_empty <= 1'b1;
                end

                if (load_go) begin
                    state   <= SHIFT;
                    sync_r  <= 1'b0;
                    sclk_r  <= 1'b1;
                    dout_r  <= buf_data[DATA_W-1];
                    div_cnt <= '0;
                    bit_cnt <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                        end
                        SHIFT: begin
                            if (div_cnt == DIV_LAST) begin
                                div_cnt <= '0;
                                if (sclk_r) begin
                                    sclk_r <= 1'b0;
                                end else if (bit_cnt == BIT_LAST) begin
                                    state   <= GAP;
                                    sync_r  <= 1'b1;
                                    sclk_r  <= 1'b1;
                                    dout_r  <= 1'b0;
                                    done_r  <= 1'b1;
                                    gap_cnt <= '0;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                    sclk_r  <= 1'b1;
                                    dout_r  <= shreg[DATA_W-2];
                                end
                            end else begin
                                div_cnt <= div_cnt + 1'b1;
                            end
                        end
                        GAP: begin
                            if (gap_cnt == GAP_LAST) begin
                                state <= IDLE;
                            end else begin
                                gap_cnt <= gap_cnt + 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end

        assign in_ready[k] = buf_empty;
        assign dout[k]     = dout_r;
        assign sclk[k]     = sclk_r;
        assign sync_n[k]   = sync_r;
        assign done[k]     = done_r;
        assign busy[k]     = (state != IDLE) || buf_full;
    end

endmodule

// File: tb/tb_spi_dac_mc.sv
// Directed bench for spi_dac_mc: default 2x8-bit instance plus a 16-bit CLK_DIV=3 instance.
// Dedup expectations follow SPI_DAC_DEDUP_EN when the bench is built with it.
module tb_spi_dac_mc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_data = '0;
    logic [1:0]  in_valid = '0;
    logic [1:0]  in_ready, dout, sclk, sync_n, busy, done;

    logic [15:0] in_data2 = '0;
    logic        in_valid2 = 1'b0;
    logic        in_ready2, dout2, sclk2, sync_n2, busy2, done2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic watch1 = 1'b0;
    int idle_bad = 0;
    int done_cnt0 = 0;
    int fall_cnt0 = 0;
    logic prev_sync0 = 1'b1;

    always #5 clk = ~clk;

    spi_dac_mc #(.NCH(2), .DATA_W(8), .CLK_DIV(1), .GAP_CYC(2)) u_dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .dout(dout), .sclk(sclk), .sync_n(sync_n),
        .busy(busy), .done(done)
    );

    spi_dac_mc #(.NCH(1), .DATA_W(16), .CLK_DIV(3), .GAP_CYC(2)) u_dut2 (
        .clk(clk), .reset(reset), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .dout(dout2), .sclk(sclk2), .sync_n(sync_n2),
        .busy(busy2), .done(done2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (watch1 && (!sync_n[1] || !sclk[1] || busy[1])) idle_bad <= idle_bad + 1;
        if (done[0]) done_cnt0 <= done_cnt0 + 1;
        if (prev_sync0 && !sync_n[0]) fall_cnt0 <= fall_cnt0 + 1;
        prev_sync0 <= sync_n[0];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input int ch, input logic [7:0] w, output int cap);
        int t = 0;
        in_data[ch*8 +: 8] = w;
        in_valid[ch] = 1'b1;
        while (!in_ready[ch] && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("handshake", in_ready[ch], 1);
        cap = cyc;
        @(negedge clk);
        in_valid[ch] = 1'b0;
    endtask

    task automatic wait_frame(input int ch, output int t0, output int t1,
                              output logic [31:0] w, output int nb, output logic dn);
        int t = 0;
        logic prev;
        w = '0; nb = 0; dn = 1'b0; t0 = 0; t1 = 0;
        while (sync_n[ch] && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("frame_start", sync_n[ch], 0);
        t0 = cyc;
        prev = 1'b1;
        t = 0;
        while (!sync_n[ch] && t < 400) begin
            if (prev && !sclk[ch]) begin
                w = {w[30:0], dout[ch]};
                nb++;
            end
            prev = sclk[ch];
            @(negedge clk);
            t++;
        end
        t1 = cyc;
        dn = done[ch];
    endtask

    initial begin
        int cap, cap2, a0, a1, b0, b1, nb, nb2, t, falls, run, bad, ones, low, d0, f0, exp_frames;
        logic [31:0] w, w2;
        logic dn, dn2, prev, prevs;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 2'b11);
        check("rst_sync_n", sync_n, 2'b11);
        check("rst_sclk", sclk, 2'b11);
        check("rst_dout", dout, 2'b00);
        check("rst_busy", busy, 2'b00);
        check("rst_done", done, 2'b00);
        reset = 1'b0;
        @(negedge clk);

        // Single word A5 on ch0, ch1 must stay idle
        watch1 = 1'b1;
        fork
            send(0, 8'hA5, cap);
            wait_frame(0, a0, a1, w, nb, dn);
        join
        watch1 = 1'b0;
        check("a5_latency", a0 - cap, 2);
        check("a5_low_cyc", a1 - a0, 16);
        check("a5_word", w, 32'hA5);
        check("a5_nbits", nb, 8);
        check("a5_done", dn, 1);
        @(negedge clk);
        check("a5_done_once", done[0], 0);
        check("ch1_idle", idle_bad, 0);

        // Back-to-back on ch1
        fork
            begin
                send(1, 8'h55, cap);
                send(1, 8'hAA, cap2);
            end
            begin
                wait_frame(1, a0, a1, w, nb, dn);
                wait_frame(1, b0, b1, w2, nb2, dn2);
            end
        join
        check("b2b_word1", w, 32'h55);
        check("b2b_word2", w2, 32'hAA);
        check("b2b_cap_in_frame1", (cap2 >= a0) && (cap2 < a1), 1);
        check("b2b_gap", b0 - a1, 2);
        check("b2b_low2", b1 - b0, 16);
        check("b2b_done2", dn2, 1);

        // Simultaneous words on both channels
        repeat (5) @(negedge clk);
        check("sim_ready", in_ready, 2'b11);
        in_data = {8'hF0, 8'h0F};
        in_valid = 2'b11;
        @(negedge clk);
        in_valid = 2'b00;
        fork
            wait_frame(0, a0, a1, w, nb, dn);
            wait_frame(1, b0, b1, w2, nb2, dn2);
        join
        check("sim_start", a0, b0);
        check("sim_end", a1, b1);
        check("sim_len", a1 - a0, 16);
        check("sim_word0", w, 32'h0F);
        check("sim_word1", w2, 32'hF0);
        check("sim_done", {dn, dn2}, 2'b11);

        // 16-bit word with CLK_DIV=3
        repeat (3) @(negedge clk);
        in_data2 = 16'h8001;
        in_valid2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        check("div3_captured", in_ready2, 0);
        t = 0;
        while (sync_n2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("div3_start", sync_n2, 0);
        low = 0; nb = 0; ones = 0; bad = 0; run = 0; w = '0;
        prev = 1'b1; prevs = sclk2;
        while (!sync_n2 && low < 400) begin
            if (sclk2 == prevs) run++;
            else begin
                if (run != 3) bad++;
                run = 1;
                prevs = sclk2;
            end
            if (prev && !sclk2) begin
                w = {w[30:0], dout2};
                nb++;
                if (dout2) ones++;
            end
            prev = sclk2;
            low++;
            @(negedge clk);
        end
        if (run != 3) bad++;
        check("div3_low_cyc", low, 96);
        check("div3_half_period", bad, 0);
        check("div3_word", w, 32'h8001);
        check("div3_nbits", nb, 16);
        check("div3_ones", ones, 2);
        check("div3_done", done2, 1);

        // Reset in the middle of a frame with a word buffered
        repeat (5) @(negedge clk);
        send(0, 8'hC3, cap);
        send(0, 8'h3C, cap2);
        falls = 0; t = 0; prev = sclk[0];
        while (falls < 4 && t < 100) begin
            @(negedge clk);
            if (prev && !sclk[0]) falls++;
            prev = sclk[0];
            t++;
        end
        check("mid_sync_low", sync_n[0], 0);
        check("mid_buf_full", in_ready[0], 0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_sync_n", sync_n[0], 1);
        check("abort_sclk", sclk[0], 1);
        check("abort_dout", dout[0], 0);
        check("abort_in_ready", in_ready, 2'b11);
        check("abort_busy", busy, 2'b00);
        check("abort_done", done, 2'b00);
        reset = 1'b0;
        d0 = done_cnt0;
        f0 = fall_cnt0;
        repeat (8) @(negedge clk);
        check("abort_no_frame", fall_cnt0 - f0, 0);
        check("abort_no_done", done_cnt0 - d0, 0);
        fork
            send(0, 8'h96, cap);
            wait_frame(0, a0, a1, w, nb, dn);
        join
        check("post_rst_word", w, 32'h96);
        check("post_rst_len", a1 - a0, 16);
        check("post_rst_done", dn, 1);

        // Repeated words: dedup drops repeats when enabled
        repeat (5) @(negedge clk);
`ifdef SPI_DAC_DEDUP_EN
        exp_frames = 2;
`else
        exp_frames = 4;
`endif
        d0 = done_cnt0;
        f0 = fall_cnt0;
        send(0, 8'h33, cap);
        send(0, 8'h33, cap);
        send(0, 8'h33, cap);
        send(0, 8'h34, cap);
        repeat (60) @(negedge clk);
        check("dedup_frames", fall_cnt0 - f0, exp_frames);
        check("dedup_dones", done_cnt0 - d0, exp_frames);
        check("dedup_idle", busy[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
